// File: rtl/spi_slave.sv
// spi_slave: peripheral end of the SPI link (CPOL = 0). The pins are oversampled
// in the clk domain, and data is returned on miso on the master's falling edge.
// The user side has a TX holding register and a RX register with overrun flag.
module spi_slave #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [DWIDTH-1:0] din,
    input  logic              wr,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] dout,
    output logic              rx_valid,
    input  logic              rd,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(DWIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    logic [2:0]          ss_pipe;
    logic [2:0]          sclk_pipe;
    logic [1:0]          mosi_pipe;
    logic [DWIDTH-1:0]   hold_reg;
    logic [DWIDTH-1:0]   tx_shift;
    logic [DWIDTH-2:0]   rx_shift;
    logic [CW-1:0]       bit_cnt;
    logic                word_done;

    logic                ss_fall;
    logic                ss_rise;
    logic                sclk_rise;
    logic                sclk_fall;
    logic [DWIDTH-1:0]   rx_next;
    logic [DWIDTH-1:0]   load_val;

    // Edges are taken between the synchronised flop and the extra delay flop.
    assign ss_fall   =  ss_pipe[2]   & ~ss_pipe[1];
    assign ss_rise   = ~ss_pipe[2]   &  ss_pipe[1];
    assign sclk_rise = ~sclk_pipe[2] &  sclk_pipe[1];
    assign sclk_fall =  sclk_pipe[2] & ~sclk_pipe[1];
    assign rx_next   = {rx_shift, mosi_pipe[1]};
    // An empty holding register sends zeros (underrun).
    assign load_val  = tx_ready ? '0 : hold_reg;

    // Synchronise the link pins; the reset values match the idle levels so no false edge follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_pipe   <= '1;
            sclk_pipe <= '0;
            mosi_pipe <= '0;
        end else begin
            ss_pipe   <= {ss_pipe[1:0], ss_n};
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            mosi_pipe <= {mosi_pipe[0], mosi};
        end
    end

    // Frame FSM together with the user write/read ports; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            miso      <= 1'b0;
            dout      <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            hold_reg  <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            if (wr && tx_ready) begin
                hold_reg <= din;
                tx_ready <= 1'b0;
            end
            if (rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    busy <= 1'b0;
                    if (ss_fall) begin
                        tx_shift  <= load_val;
                        miso      <= load_val[DWIDTH-1];
                        if (!tx_ready) begin
                            tx_ready <= 1'b1;
                        end
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (ss_rise) begin
                        state     <= IDLE;
                        miso      <= 1'b0;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[DWIDTH-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            busy      <= 1'b0;
                            word_done <= 1'b1;
                            if (!rx_valid || rd) begin
                                dout     <= rx_next;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            busy    <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= tx_shift << 1;
                            miso     <= tx_shift[DWIDTH-2];
                        end else if (word_done) begin
                            tx_shift  <= load_val;
                            miso      <= load_val[DWIDTH-1];
                            if (!tx_ready) begin
                                tx_ready <= 1'b1;
                            end
                            word_done <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
